dh_match_ctrl: RTL and testbench
================================

// Module: dh_match_ctrl
// PURPOSE
//  Match sequencer for two-board Duck Hunt play: runs countdown, timed round, pause and result phases.
//  Sits inside top_DH beside the game datapath, on the 65 MHz pixel clock. Consumes local score/pause
//  and the raw player-2 link (pause, score[3:0]). Drives game freeze/enable, timers and the winner.
// PARAMETERS
//  CLK_HZ        65_000_000  clock cycles per one-second tick
//  COUNTDOWN_SEC 3           countdown length in seconds, 1..9
//  ROUND_SEC     60          round length in seconds, 1..63
//  WIN_SCORE     15          score that ends a round immediately, 1..15
//  STABLE_CYC    4           consecutive equal samples before a remote score is accepted
// PORTS
//  clk               in   1  system clock, 65 MHz
//  rst               in   1  synchronous reset, active-high
//  start             in   1  single-cycle start/restart pulse, already debounced
//  local_pause       in   1  local pause request, level, synchronous
//  local_score       in   4  local player hit count, synchronous
//  remote_pause_raw  in   1  player-2 pause, asynchronous
//  remote_score_raw  in   4  player-2 score, asynchronous, multi-bit
//  game_en           out  1  1 = ducks move and hits count (PLAY only)
//  score_clr         out  1  1-cycle pulse that clears both scores when COUNTDOWN is entered
//  countdown         out  4  remaining countdown seconds; 0 outside COUNTDOWN
//  time_left         out  6  remaining round seconds
//  remote_score      out  4  filtered remote score
//  winner            out  2  00 none, 01 local, 10 remote, 11 draw; valid in RESULT
//  phase             out  3  IDLE=0 COUNTDOWN=1 PLAY=2 PAUSED=3 RESULT=4 (OVERTIME=5 with macro)
// BEHAVIOUR
//  - Reset values: phase=IDLE, game_en=0, score_clr=0, countdown=0, time_left=ROUND_SEC,
//    remote_score=0, winner=00. Prescaler and filter are cleared. Reset overrides every other event.
//  - remote_*_raw: 2-FF synchronizer. remote_score updates only after the synchronized value
//    has held for STABLE_CYC consecutive cycles; otherwise it keeps its previous value.
//  - pause_any = local_pause | synchronized remote pause.
//  - Tick: prescaler counts 0..CLK_HZ-1 and gives a 1-cycle tick at wrap. It runs only in COUNTDOWN
//    and PLAY, holds its value in PAUSED, and clears whenever COUNTDOWN is entered.
//  - IDLE -> COUNTDOWN on start. Entry pulses score_clr, sets countdown=COUNTDOWN_SEC,
//    time_left=ROUND_SEC and winner=00.
//  - COUNTDOWN: each tick decrements countdown. On the tick where countdown==1 it goes to 0 -> PLAY.
//  - PLAY: game_en=1. Each tick decrements time_left.
//    Same-cycle priority: win score > pause > tick.
//    If local_score>=WIN_SCORE or remote_score>=WIN_SCORE -> RESULT (both reaching it -> draw).
//    Else if pause_any -> PAUSED. Else if a tick arrives with time_left==1 -> time_left=0 -> RESULT.
//  - PAUSED: game_en=0 and all timers frozen. When pause_any drops, the next cycle returns to PLAY.
//  - RESULT: winner compares local_score with remote_score (greater wins, equal = 11).
//    It latches on the entry cycle and holds until the next start.
//  - start while in COUNTDOWN, PLAY, PAUSED or RESULT restarts through the COUNTDOWN entry. Scores cleared.
//  - Outputs are registered; phase change is visible the cycle after the causing input.
//  - time_left never wraps below 0; countdown never wraps below 0.
// CONFIGURATION
//  DH_MATCH_OVERTIME_EN defined: a draw at time expiry (time_left reaches 0) enters OVERTIME instead
//    of RESULT. OVERTIME: game_en=1, time_left=0, and pause is handled as in PLAY, returning to OVERTIME.
//    The first change of either score -> RESULT with the changed side as winner.
//    Simultaneous change of both scores -> draw (11).
//    A draw at WIN_SCORE still goes directly to RESULT.
//  Not defined: a time-expiry draw goes to RESULT with winner=11. Encoding 5 is unused.
// TESTING
//  1. CLK_HZ=10, COUNTDOWN_SEC=3: start -> score_clr pulse; countdown 3,2,1 spaced 10 cycles;
//     PLAY reached 30 cycles after start, game_en=1.
//  2. ROUND_SEC=2, local=5, remote=3 -> after 20 PLAY cycles phase=RESULT, winner=01, game_en=0.
//  3. Pause at PLAY cycle 7 held for 50 cycles -> PAUSED, time_left frozen.
//     On release the remaining 3 cycles complete the tick.
//  4. remote_score_raw glitches 3->7 for 2 cycles, then settles to 4 -> remote_score never shows 7;
//     shows 4 after 2+STABLE_CYC cycles.
//  5. local_score=15 and a tick with time_left==1 in the same cycle -> RESULT with winner=01 (win score priority).
//  6. Draw 4:4 at expiry: with the macro -> OVERTIME, then remote goes to 5 -> RESULT, winner=10.
//     Without the macro -> RESULT, winner=11.
//     rst mid-PLAY -> IDLE with all outputs at reset values next cycle.

Source files
------------

// File: rtl/dh_match_ctrl_if.sv
// Signal bundle between the Duck Hunt match sequencer, the game datapath and the player-2 link.
// The sequencer attaches through the slave modport; the datapath/link side uses master.
interface dh_match_ctrl_if;
    logic       start;
    logic       local_pause;
    logic [3:0] local_score;
    logic       remote_pause_raw;
    logic [3:0] remote_score_raw;
    logic       game_en;
    logic       score_clr;
    logic [3:0] countdown;
    logic [5:0] time_left;
    logic [3:0] remote_score;
    logic [1:0] winner;
    logic [2:0] phase;

    modport master (
        output start, local_pause, local_score, remote_pause_raw, remote_score_raw,
        input  game_en, score_clr, countdown, time_left, remote_score, winner, phase
    );

    modport slave (
        input  start, local_pause, local_score, remote_pause_raw, remote_score_raw,
        output game_en, score_clr, countdown, time_left, remote_score, winner, phase
    );
endinterface

// File: rtl/dh_match_ctrl.sv
// Two-board Duck Hunt match sequencer: countdown, timed round, pause and result phases.
// Optional macro DH_MATCH_OVERTIME_EN: a draw at time expiry enters a sudden-death OVERTIME phase.
module dh_match_ctrl #(
    parameter int CLK_HZ        = 65_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int ROUND_SEC     = 60,
    parameter int WIN_SCORE     = 15,
    parameter int STABLE_CYC    = 4
) (
    input  logic           clk,
    input  logic           rst,
    dh_match_ctrl_if.slave bus
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW = $clog2(STABLE_CYC + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0]    CD_INIT   = 4'(COUNTDOWN_SEC);
    localparam logic [5:0]    TL_INIT   = 6'(ROUND_SEC);
    localparam logic [3:0]    WIN_V     = 4'(WIN_SCORE);
    localparam logic [SW-1:0] STABLE_V  = SW'(STABLE_CYC);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSED    = 3'd3,
        S_RESULT    = 3'd4,
        S_OVERTIME  = 3'd5
    } phase_t;

    // Two-flop synchronizers for the player-2 link: bit 4 is pause, bits 3:0 are the score.
    logic [4:0] raw_vec;
    logic [4:0] sync_vec;
    assign raw_vec = {bus.remote_pause_raw, bus.remote_score_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= raw_vec[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    logic [3:0]    rs_sync;
    logic          rp_sync;
    logic [3:0]    cand_reg;
    logic [SW-1:0] run_reg;
    logic [SW-1:0] run_len;
    logic [3:0]    remote_score_reg;

    assign rs_sync = sync_vec[3:0];
    assign rp_sync = sync_vec[4];

    // run_len = number of consecutive cycles the synchronized score has shown its current value.
    assign run_len = (rs_sync != cand_reg) ? SW'(1) :
                     (run_reg == STABLE_V) ? STABLE_V : run_reg + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_reg         <= 4'd0;
            run_reg          <= '0;
            remote_score_reg <= 4'd0;
        end else begin
            cand_reg <= rs_sync;
            run_reg  <= run_len;
            if (run_len >= STABLE_V) begin
                remote_score_reg <= rs_sync;
            end
        end
    end

    phase_t        phase_reg, phase_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [3:0]    countdown_reg, countdown_next;
    logic [5:0]    time_left_reg, time_left_next;
    logic [1:0]    winner_reg, winner_next;
    logic          score_clr_reg, score_clr_next;
    logic          game_en_reg, game_en_next;
`ifdef DH_MATCH_OVERTIME_EN
    logic          ot_pause_reg, ot_pause_next;
    logic [3:0]    ot_local_reg, ot_local_next;
    logic [3:0]    ot_remote_reg, ot_remote_next;
    logic          ch_local, ch_remote;
`endif

    logic pause_any;
    logic at_max;
    logic win_local, win_remote;

    assign pause_any  = bus.local_pause | rp_sync;
    assign at_max     = (presc_reg == PRESC_MAX);
    assign win_local  = (bus.local_score >= WIN_V);
    assign win_remote = (remote_score_reg >= WIN_V);
`ifdef DH_MATCH_OVERTIME_EN
    assign ch_local   = (bus.local_score != ot_local_reg);
    assign ch_remote  = (remote_score_reg != ot_remote_reg);
`endif

    always_comb begin
        phase_next     = phase_reg;
        presc_next     = presc_reg;
        countdown_next = countdown_reg;
        time_left_next = time_left_reg;
        winner_next    = winner_reg;
        score_clr_next = 1'b0;
`ifdef DH_MATCH_OVERTIME_EN
        ot_pause_next  = ot_pause_reg;
        ot_local_next  = ot_local_reg;
        ot_remote_next = ot_remote_reg;
`endif
        if (bus.start) begin
            phase_next     = S_COUNTDOWN;
            presc_next     = '0;
            countdown_next = CD_INIT;
            time_left_next = TL_INIT;
            winner_next    = 2'b00;
            score_clr_next = 1'b1;
`ifdef DH_MATCH_OVERTIME_EN
            ot_pause_next  = 1'b0;
`endif
        end else begin
            case (phase_reg)
                S_COUNTDOWN: begin
                    if (at_max) begin
                        presc_next = '0;
                        if (countdown_reg <= 4'd1) begin
                            countdown_next = 4'd0;
                            phase_next     = S_PLAY;
                        end else begin
                            countdown_next = countdown_reg - 4'd1;
                        end
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
                S_PLAY: begin
                    // The prescaler only advances on cycles where a tick could actually be taken.
                    if (win_local || win_remote) begin
                        phase_next  = S_RESULT;
                        winner_next = {win_remote, win_local};
                    end else if (pause_any) begin
                        phase_next = S_PAUSED;
`ifdef DH_MATCH_OVERTIME_EN
                        ot_pause_next = 1'b0;
`endif
                    end else if (at_max) begin
                        presc_next = '0;
                        if (time_left_reg <= 6'd1) begin
                            time_left_next = 6'd0;
                            phase_next     = S_RESULT;
                            if (bus.local_score > remote_score_reg) begin
                                winner_next = 2'b01;
                            end else if (bus.local_score < remote_score_reg) begin
                                winner_next = 2'b10;
                            end else begin
`ifdef DH_MATCH_OVERTIME_EN
                                phase_next     = S_OVERTIME;
                                ot_local_next  = bus.local_score;
                                ot_remote_next = remote_score_reg;
`else
                                winner_next    = 2'b11;
`endif
                            end
                        end else begin
                            time_left_next = time_left_reg - 6'd1;
                        end
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
                S_PAUSED: begin
                    if (!pause_any) begin
`ifdef DH_MATCH_OVERTIME_EN
                        phase_next = ot_pause_reg ? S_OVERTIME : S_PLAY;
`else
                        phase_next = S_PLAY;
`endif
                    end
                end
`ifdef DH_MATCH_OVERTIME_EN
                S_OVERTIME: begin
                    // Sudden death: whichever score moves first decides the match.
                    if (ch_local || ch_remote) begin
                        phase_next  = S_RESULT;
                        winner_next = {ch_remote, ch_local};
                    end else if (pause_any) begin
                        phase_next    = S_PAUSED;
                        ot_pause_next = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
        game_en_next = (phase_next == S_PLAY) || (phase_next == S_OVERTIME);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg     <= S_IDLE;
            presc_reg     <= '0;
            countdown_reg <= 4'd0;
            time_left_reg <= TL_INIT;
            winner_reg    <= 2'b00;
            score_clr_reg <= 1'b0;
            game_en_reg   <= 1'b0;
`ifdef DH_MATCH_OVERTIME_EN
            ot_pause_reg  <= 1'b0;
            ot_local_reg  <= 4'd0;
            ot_remote_reg <= 4'd0;
`endif
        end else begin
            phase_reg     <= phase_next;
            presc_reg     <= presc_next;
            countdown_reg <= countdown_next;
            time_left_reg <= time_left_next;
            winner_reg    <= winner_next;
            score_clr_reg <= score_clr_next;
            game_en_reg   <= game_en_next;
`ifdef DH_MATCH_OVERTIME_EN
            ot_pause_reg  <= ot_pause_next;
            ot_local_reg  <= ot_local_next;
            ot_remote_reg <= ot_remote_next;
`endif
        end
    end

    assign bus.phase        = phase_reg;
    assign bus.game_en      = game_en_reg;
    assign bus.score_clr    = score_clr_reg;
    assign bus.countdown    = countdown_reg;
    assign bus.time_left    = time_left_reg;
    assign bus.remote_score = remote_score_reg;
    assign bus.winner       = winner_reg;
endmodule

// File: tb/tb_dh_match_ctrl.sv
// Scoreboard bench for dh_match_ctrl: a cycle-level match model queues expected outputs,
// a monitor on the falling edge pops and compares them; directed scenarios then random play.
module tb_dh_match_ctrl;
    localparam int CLK_HZ        = 10;
    localparam int COUNTDOWN_SEC = 3;
    localparam int ROUND_SEC     = 2;
    localparam int WIN_SCORE     = 15;
    localparam int STABLE_CYC    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dh_match_ctrl_if bus ();

    dh_match_ctrl #(
        .CLK_HZ(CLK_HZ), .COUNTDOWN_SEC(COUNTDOWN_SEC), .ROUND_SEC(ROUND_SEC),
        .WIN_SCORE(WIN_SCORE), .STABLE_CYC(STABLE_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int phase;
        int game_en;
        int score_clr;
        int countdown;
        int time_left;
        int remote_score;
        int winner;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Match model state: phase numbers, whole seconds, and cycles elapsed in the current second.
    int m_phase, m_cd, m_tl, m_win, m_sub, m_remote;
    int m_clr, m_ot_from, m_ot_l, m_ot_r;
    int d1_s, d2_s, d1_p, d2_p;
    int seen[$];

    always @(posedge clk) begin
        exp_t e;
        int sync_s, sync_p, rem_now, loc, pause, lw, rw, cl, cr, all_eq;
        if (rst) begin
            m_phase = 0; m_cd = 0; m_tl = ROUND_SEC; m_win = 0; m_sub = 0; m_remote = 0;
            m_clr = 0; m_ot_from = 0; m_ot_l = 0; m_ot_r = 0;
            d1_s = 0; d2_s = 0; d1_p = 0; d2_p = 0;
            seen.delete();
        end else begin
            sync_s = d2_s; sync_p = d2_p;
            d2_s = d1_s; d1_s = int'(bus.remote_score_raw);
            d2_p = d1_p; d1_p = int'(bus.remote_pause_raw);
            seen.push_back(sync_s);
            if (seen.size() > STABLE_CYC) void'(seen.pop_front());
            all_eq = (seen.size() == STABLE_CYC);
            foreach (seen[i]) if (seen[i] != sync_s) all_eq = 0;

            rem_now = m_remote;
            loc     = int'(bus.local_score);
            pause   = int'(bus.local_pause) | sync_p;
            m_clr   = 0;
            if (bus.start) begin
                m_phase = 1; m_clr = 1; m_cd = COUNTDOWN_SEC; m_tl = ROUND_SEC;
                m_win = 0; m_sub = 0; m_ot_from = 0;
            end else begin
                case (m_phase)
                    1: begin
                        if (m_sub == CLK_HZ - 1) begin
                            m_sub = 0;
                            m_cd  = m_cd - 1;
                            if (m_cd == 0) m_phase = 2;
                        end else m_sub++;
                    end
                    2: begin
                        lw = (loc >= WIN_SCORE);
                        rw = (rem_now >= WIN_SCORE);
                        if (lw || rw) begin
                            m_phase = 4;
                            m_win = (lw && rw) ? 3 : (lw ? 1 : 2);
                        end else if (pause) begin
                            m_phase = 3; m_ot_from = 0;
                        end else if (m_sub == CLK_HZ - 1) begin
                            m_sub = 0;
                            m_tl  = m_tl - 1;
                            if (m_tl == 0) begin
                                if (loc > rem_now) begin m_phase = 4; m_win = 1; end
                                else if (loc < rem_now) begin m_phase = 4; m_win = 2; end
                                else begin
`ifdef DH_MATCH_OVERTIME_EN
                                    m_phase = 5; m_ot_l = loc; m_ot_r = rem_now;
`else
                                    m_phase = 4; m_win = 3;
`endif
                                end
                            end
                        end else m_sub++;
                    end
                    3: if (!pause) m_phase = m_ot_from ? 5 : 2;
                    5: begin
                        cl = (loc != m_ot_l);
                        cr = (rem_now != m_ot_r);
                        if (cl || cr) begin
                            m_phase = 4; m_win = cl + 2 * cr;
                        end else if (pause) begin
                            m_phase = 3; m_ot_from = 1;
                        end
                    end
                    default: ;
                endcase
            end
            if (all_eq) m_remote = sync_s;
        end
        e.phase        = m_phase;
        e.game_en      = (m_phase == 2 || m_phase == 5) ? 1 : 0;
        e.score_clr    = m_clr;
        e.countdown    = m_cd;
        e.time_left    = m_tl;
        e.remote_score = m_remote;
        e.winner       = m_win;
        exp_q.push_back(e);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    int last_phase = -1;
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("phase",        int'(bus.phase),        e.phase);
            check("game_en",      int'(bus.game_en),      e.game_en);
            check("score_clr",    int'(bus.score_clr),    e.score_clr);
            check("countdown",    int'(bus.countdown),    e.countdown);
            check("time_left",    int'(bus.time_left),    e.time_left);
            check("remote_score", int'(bus.remote_score), e.remote_score);
            check("winner",       int'(bus.winner),       e.winner);
            if (e.phase != last_phase) begin
                $display("t=%0t phase %0d -> %0d countdown=%0d time_left=%0d remote=%0d winner=%0d",
                         $time, last_phase, e.phase, e.countdown, e.time_left, e.remote_score, e.winner);
                last_phase = e.phase;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.local_pause = 1'b0; bus.local_score = 4'd0;
        bus.remote_pause_raw = 1'b0; bus.remote_score_raw = 4'd0;
        cyc(3);
        rst = 1'b0;

        // Countdown then a 5:3 round decided at expiry.
        bus.local_score = 4'd5; bus.remote_score_raw = 4'd3;
        cyc(8);
        pulse_start();
        cyc(60);

        // Pause at PLAY cycle 7 for 50 cycles.
        pulse_start();
        cyc(36);
        bus.local_pause = 1'b1;
        cyc(50);
        bus.local_pause = 1'b0;
        cyc(30);

        // Remote glitch 3 -> 7 for two cycles, then settles to 4.
        bus.remote_score_raw = 4'd7;
        cyc(2);
        bus.remote_score_raw = 4'd4;
        cyc(12);

        // Win score on the same cycle as the final tick.
        bus.local_score = 4'd0;
        pulse_start();
        cyc(48);
        bus.local_score = 4'd15;
        cyc(5);

        // 4:4 draw at expiry, then remote scores.
        bus.local_score = 4'd4;
        pulse_start();
        cyc(60);
        bus.remote_score_raw = 4'd5;
        cyc(15);

        // Draw again, pause from the link during the tie phase, then local scores.
        bus.remote_score_raw = 4'd4;
        pulse_start();
        cyc(60);
        bus.remote_pause_raw = 1'b1;
        cyc(10);
        bus.remote_pause_raw = 1'b0;
        cyc(6);
        bus.local_score = 4'd6;
        cyc(5);

        // Reset mid-PLAY.
        pulse_start();
        cyc(35);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(5);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 39) == 0) bus.local_pause = ~bus.local_pause;
            if ($urandom_range(0, 79) == 0) bus.remote_pause_raw = ~bus.remote_pause_raw;
            if ($urandom_range(0, 24) == 0)
                bus.local_score = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 14) == 0)
                bus.remote_score_raw = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 9));
            rst = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
